// File: rtl/uloop_sequencer.sv
// uloop_sequencer
// Microcode program-counter sequencer with NUM_LOOPS hardware loop slots.
// Drives upc into the microinstruction ROM and consumes the loop-store,
// loop-update, jump and done fields of the fetched instruction in the same
// cycle.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, upc_start      one-cycle start pulse and first instruction address
//   done                  end-of-program flag (ignored in IDLE)
//   stall                 freeze upc and loop state for this cycle
//   loop_count            packed per-slot loop counts
//   st_en/st_idx          loop-start marker and slot
//   up_en/up_idx          loop-end marker and slot
//   jump_en/jump_addr     unconditional jump
//   upc                   registered microinstruction address
//   busy                  high while running
//   finish                one-cycle pulse when a run ends through done
//   loop_act              per-slot "counter nonzero" flags (registered)
module uloop_sequencer #(
    parameter int UINST_ADDR_WIDTH = 8,
    parameter int LOOP_CNT_WIDTH   = 11,
    parameter int NUM_LOOPS        = 4,
    localparam int LOOP_IDX_W      = $clog2(NUM_LOOPS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [UINST_ADDR_WIDTH-1:0]         upc_start,
    input  logic                                done,
    input  logic                                stall,
    input  logic [NUM_LOOPS*LOOP_CNT_WIDTH-1:0] loop_count,
    input  logic                                st_en,
    input  logic [LOOP_IDX_W-1:0]               st_idx,
    input  logic                                up_en,
    input  logic [LOOP_IDX_W-1:0]               up_idx,
    input  logic                                jump_en,
    input  logic [UINST_ADDR_WIDTH-1:0]         jump_addr,
    output logic [UINST_ADDR_WIDTH-1:0]         upc,
    output logic                                busy,
    output logic                                finish,
    output logic [NUM_LOOPS-1:0]                loop_act
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [UINST_ADDR_WIDTH-1:0] upc_q, upc_d;
    logic [UINST_ADDR_WIDTH-1:0] addr_q [NUM_LOOPS];
    logic [UINST_ADDR_WIDTH-1:0] addr_d [NUM_LOOPS];
    logic [LOOP_CNT_WIDTH-1:0]   cnt_q  [NUM_LOOPS];
    logic [LOOP_CNT_WIDTH-1:0]   cnt_d  [NUM_LOOPS];
    logic                        finish_q, finish_d;
    logic [NUM_LOOPS-1:0]        loop_act_q, loop_act_d;

    logic                        running;
    logic                        take_branch;
    logic                        update_valid;
    logic [UINST_ADDR_WIDTH-1:0] upc_inc;

    assign running = (state_q == RUN);
    assign upc_inc = upc_q + UINST_ADDR_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        finish_d    = 1'b0;
        take_branch = 1'b0;
        // A store to the same slot in the same instruction supersedes the update.
        update_valid = up_en && !(st_en && (st_idx == up_idx));

        if (start) begin
            state_d = RUN;
            upc_d   = upc_start;
            for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
                addr_d[i] = '0;
                cnt_d[i]  = '0;
            end
        end else if (running && done) begin
            state_d  = IDLE;
            upc_d    = '0;
            finish_d = 1'b1;
            for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
                addr_d[i] = '0;
                cnt_d[i]  = '0;
            end
        end else if (running && !stall) begin
            if (update_valid) begin
                // Count N means N body passes: branch back while more than one remains.
                if (cnt_q[up_idx] > LOOP_CNT_WIDTH'(1)) begin
                    take_branch    = 1'b1;
                    cnt_d[up_idx]  = cnt_q[up_idx] - LOOP_CNT_WIDTH'(1);
                end else begin
                    cnt_d[up_idx]  = '0;
                end
            end
            if (st_en) begin
                addr_d[st_idx] = upc_inc;
                cnt_d[st_idx]  = loop_count[st_idx*LOOP_CNT_WIDTH +: LOOP_CNT_WIDTH];
            end
            if (take_branch) begin
                upc_d = addr_q[up_idx];
            end else if (jump_en) begin
                upc_d = jump_addr;
            end else begin
                upc_d = upc_inc;
            end
        end

        for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
            loop_act_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            upc_q      <= '0;
            addr_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            finish_q   <= 1'b0;
            loop_act_q <= '0;
        end else begin
            state_q    <= state_d;
            upc_q      <= upc_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            finish_q   <= finish_d;
            loop_act_q <= loop_act_d;
        end
    end

    assign upc      = upc_q;
    assign busy     = (state_q == RUN);
    assign finish   = finish_q;
    assign loop_act = loop_act_q;

endmodule

// File: tb/tb_uloop_sequencer.sv
// Testbench for uloop_sequencer: directed microprograms held in a bench ROM
// plus randomized control traffic, all checked against a behavioural model.
module tb_uloop_sequencer;

    localparam int AW = 8;
    localparam int CW = 11;
    localparam int NL = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   upc_start;
    logic            done;
    logic            stall;
    logic [NL*CW-1:0] loop_count;
    logic            st_en;
    logic [IW-1:0]   st_idx;
    logic            up_en;
    logic [IW-1:0]   up_idx;
    logic            jump_en;
    logic [AW-1:0]   jump_addr;
    logic [AW-1:0]   upc;
    logic            busy;
    logic            finish;
    logic [NL-1:0]   loop_act;

    uloop_sequencer #(
        .UINST_ADDR_WIDTH(AW),
        .LOOP_CNT_WIDTH(CW),
        .NUM_LOOPS(NL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .upc_start(upc_start),
        .done(done), .stall(stall), .loop_count(loop_count),
        .st_en(st_en), .st_idx(st_idx), .up_en(up_en), .up_idx(up_idx),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .upc(upc), .busy(busy), .finish(finish), .loop_act(loop_act)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: program counter, run flag, per-slot loop address/count.
    int m_upc;
    bit m_run;
    int m_addr [NL];
    int m_cnt  [NL];
    bit m_fin;

    int hits [256];

    typedef struct {
        bit st; int sti; int cnt;
        bit up; int upi;
        bit jmp; int ja;
        bit dn;
    } uinst_t;
    uinst_t rom [256];

    int stall_at   = -1;
    int stall_left = 0;

    task automatic model_reset();
        m_upc = 0; m_run = 0; m_fin = 0;
        for (int i = 0; i < NL; i++) begin m_addr[i] = 0; m_cnt[i] = 0; end
    endtask

    task automatic clear_drives();
        start = 0; upc_start = '0; done = 0; stall = 0; loop_count = '0;
        st_en = 0; st_idx = '0; up_en = 0; up_idx = '0; jump_en = 0; jump_addr = '0;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) begin
            rom[a] = '{st: 0, sti: 0, cnt: 0, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
            hits[a] = 0;
        end
    endtask

    // Advance one clock; model computes the next state from the driven inputs.
    task automatic tick(input string tag);
        int nupc; bit nrun; bit nfin; bit br; int tgt;
        int naddr [NL]; int ncnt [NL];
        logic [NL-1:0] ea;
        nupc = m_upc; nrun = m_run; nfin = 0; br = 0; tgt = 0;
        naddr = m_addr; ncnt = m_cnt;
        if (busy === 1'b1 && !stall) hits[upc]++;
        if (start) begin
            nrun = 1; nupc = upc_start;
            for (int i = 0; i < NL; i++) begin naddr[i] = 0; ncnt[i] = 0; end
        end else if (m_run && done) begin
            nrun = 0; nupc = 0; nfin = 1;
            for (int i = 0; i < NL; i++) begin naddr[i] = 0; ncnt[i] = 0; end
        end else if (m_run && !stall) begin
            if (up_en && !(st_en && st_idx == up_idx)) begin
                if (m_cnt[up_idx] > 1) begin
                    br = 1; tgt = m_addr[up_idx]; ncnt[up_idx] = m_cnt[up_idx] - 1;
                end else begin
                    ncnt[up_idx] = 0;
                end
            end
            if (st_en) begin
                naddr[st_idx] = (m_upc + 1) % 256;
                ncnt[st_idx]  = int'(loop_count[st_idx*CW +: CW]);
            end
            if (br)           nupc = tgt;
            else if (jump_en) nupc = int'(jump_addr);
            else              nupc = (m_upc + 1) % 256;
        end
        @(posedge clk);
        m_upc = nupc; m_run = nrun; m_fin = nfin; m_addr = naddr; m_cnt = ncnt;
        #1;
        for (int i = 0; i < NL; i++) ea[i] = (m_cnt[i] != 0);
        check_eq({tag, "_upc"}, 32'(upc), 32'(m_upc));
        check_eq({tag, "_busy"}, 32'(busy), 32'(m_run));
        check_eq({tag, "_finish"}, 32'(finish), 32'(m_fin));
        check_eq({tag, "_loop_act"}, 32'(loop_act), 32'(ea));
    endtask

    // Drive the control fields of the instruction the model says is at upc.
    task automatic drive_from_rom();
        uinst_t u;
        clear_drives();
        loop_count = {$urandom, $urandom};
        if (m_run) begin
            u = rom[m_upc];
            st_en = u.st; st_idx = IW'(u.sti);
            up_en = u.up; up_idx = IW'(u.upi);
            jump_en = u.jmp; jump_addr = AW'(u.ja);
            done = u.dn;
            loop_count[u.sti*CW +: CW] = CW'(u.cnt);
            if (m_upc == stall_at && stall_left > 0) begin
                stall = 1; stall_left--;
            end
        end
    endtask

    task automatic start_prog(input int sa, input string tag);
        clear_drives();
        upc_start = AW'(sa); start = 1;
        tick({tag, "_start"});
        start = 0;
    endtask

    task automatic finish_prog(input int budget, input string tag);
        int n = 0;
        while (m_run && n < budget) begin
            drive_from_rom();
            tick(tag);
            n++;
        end
        if (m_run) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        clear_drives();
        tick({tag, "_idle"});
    endtask

    initial begin
        clear_drives();
        clear_rom();
        model_reset();
        rst = 1;
        #12;
        check_eq("reset_upc", 32'(upc), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_finish", 32'(finish), 32'd0);
        check_eq("reset_loop_act", 32'(loop_act), 32'd0);
        @(negedge clk);
        rst = 0;

        // Idle: update, jump and done are ignored.
        for (int i = 0; i < 4; i++) begin
            up_en = 1; jump_en = 1; jump_addr = 8'h40; done = i[0];
            tick("idle");
        end
        clear_drives();

        // Single loop with a 3-cycle stall at 0x12.
        clear_rom();
        rom[8'h10] = '{st: 1, sti: 0, cnt: 3, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h12] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h13].dn = 1;
        stall_at = 8'h12; stall_left = 3;
        start_prog(8'h10, "single");
        finish_prog(100, "single");
        check_eq("single_hits_11", 32'(hits[8'h11]), 32'd3);
        check_eq("single_hits_12", 32'(hits[8'h12]), 32'd3);
        check_eq("single_hits_13", 32'(hits[8'h13]), 32'd1);
        check_eq("single_stall_used", 32'(stall_left), 32'd0);
        stall_at = -1;

        // Nested loops ending with done at 0x30.
        clear_rom();
        rom[8'h20] = '{st: 1, sti: 2, cnt: 2, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h21] = '{st: 1, sti: 1, cnt: 3, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h23] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 1, jmp: 0, ja: 0, dn: 0};
        rom[8'h25] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 2, jmp: 0, ja: 0, dn: 0};
        rom[8'h30].dn = 1;
        start_prog(8'h20, "nested");
        finish_prog(200, "nested");
        check_eq("nested_hits_22", 32'(hits[8'h22]), 32'd6);
        check_eq("nested_hits_24", 32'(hits[8'h24]), 32'd2);
        check_eq("nested_hits_26", 32'(hits[8'h26]), 32'd1);
        check_eq("nested_hits_30", 32'(hits[8'h30]), 32'd1);

        // Counts 0 and 1 each run the body once.
        clear_rom();
        rom[8'h70] = '{st: 1, sti: 0, cnt: 0, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h71] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h72] = '{st: 1, sti: 1, cnt: 1, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h73] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 1, jmp: 0, ja: 0, dn: 0};
        rom[8'h74].dn = 1;
        start_prog(8'h70, "cnt01");
        finish_prog(50, "cnt01");
        check_eq("cnt0_hits_71", 32'(hits[8'h71]), 32'd1);
        check_eq("cnt1_hits_73", 32'(hits[8'h73]), 32'd1);

        // Maximum count: 2047 passes.
        clear_rom();
        rom[8'h60] = '{st: 1, sti: 3, cnt: 2047, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h62] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 3, jmp: 0, ja: 0, dn: 0};
        rom[8'h63].dn = 1;
        start_prog(8'h60, "cntmax");
        finish_prog(5000, "cntmax");
        check_eq("cntmax_hits_61", 32'(hits[8'h61]), 32'd2047);
        check_eq("cntmax_hits_63", 32'(hits[8'h63]), 32'd1);

        // Update combined with jump: branch while live, jump once exhausted.
        clear_rom();
        rom[8'h38] = '{st: 1, sti: 3, cnt: 2, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h39] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 3, jmp: 1, ja: 8'h40, dn: 0};
        rom[8'h40].dn = 1;
        start_prog(8'h38, "jump");
        finish_prog(50, "jump");
        check_eq("jump_hits_39", 32'(hits[8'h39]), 32'd2);
        check_eq("jump_hits_3a", 32'(hits[8'h3A]), 32'd0);
        check_eq("jump_hits_40", 32'(hits[8'h40]), 32'd1);

        // Restart during a live loop, then start colliding with done.
        clear_rom();
        rom[8'h10] = '{st: 1, sti: 0, cnt: 3, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h12] = '{st: 0, sti: 0, cnt: 0, up: 1, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h13].dn = 1;
        rom[8'h50].dn = 1;
        start_prog(8'h10, "restart");
        for (int n = 0; n < 20 && !(m_upc == 8'h12 && m_cnt[0] == 2); n++) begin
            drive_from_rom();
            tick("restart_run");
        end
        check_eq("restart_reached", 32'(m_upc == 8'h12 && m_cnt[0] == 2), 32'd1);
        check_eq("restart_act_before", 32'(loop_act[0]), 32'd1);
        drive_from_rom();
        start = 1; upc_start = 8'h50;
        tick("restart");
        check_eq("restart_upc", 32'(upc), 32'h50);
        check_eq("restart_act_clr", 32'(loop_act), 32'd0);
        check_eq("restart_busy", 32'(busy), 32'd1);
        drive_from_rom();
        check_eq("collide_done_driven", 32'(done), 32'd1);
        start = 1; upc_start = 8'h10;
        tick("collide");
        check_eq("collide_upc", 32'(upc), 32'h10);
        check_eq("collide_busy", 32'(busy), 32'd1);
        check_eq("collide_finish", 32'(finish), 32'd0);
        finish_prog(100, "restart_end");

        // Asynchronous reset mid-run at 0x23.
        clear_rom();
        rom[8'h20] = '{st: 1, sti: 2, cnt: 2, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        rom[8'h21] = '{st: 1, sti: 1, cnt: 3, up: 0, upi: 0, jmp: 0, ja: 0, dn: 0};
        start_prog(8'h20, "areset");
        for (int n = 0; n < 10 && m_upc != 8'h23; n++) begin
            drive_from_rom();
            tick("areset_run");
        end
        check_eq("areset_at_23", 32'(upc), 32'h23);
        #2 rst = 1;
        #1;
        model_reset();
        check_eq("areset_upc", 32'(upc), 32'd0);
        check_eq("areset_busy", 32'(busy), 32'd0);
        check_eq("areset_act", 32'(loop_act), 32'd0);
        @(negedge clk);
        rst = 0;
        clear_drives();
        tick("post_reset_idle");

        // Randomized control traffic.
        for (int n = 0; n < 3000; n++) begin
            start     = ($urandom_range(0, 63) == 0);
            upc_start = AW'($urandom);
            done      = ($urandom_range(0, 31) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            st_en     = ($urandom_range(0, 5) == 0);
            st_idx    = IW'($urandom);
            up_en     = ($urandom_range(0, 3) == 0);
            up_idx    = IW'($urandom);
            jump_en   = ($urandom_range(0, 9) == 0);
            jump_addr = AW'($urandom);
            for (int i = 0; i < NL; i++)
                loop_count[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
            tick("rand");
        end
        clear_drives();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uloop_sequencer.md
# uloop_sequencer

Parametrised microcode program-counter sequencer with NUM_LOOPS independent hardware loop slots, configurable counter width, stall, unconditional jump and an explicit run/finish status. It sits between the top-level command decoder and the microinstruction ROM: it receives a start address, drives `upc` into the ROM, and takes loop-store, loop-update and jump fields back from the fetched microinstruction in the same cycle. It supersedes the fixed three-slot, 11-bit loop controller.

## Interface
Parameters:
- UINST_ADDR_WIDTH, 8, width of `upc`, `upc_start`, `jump_addr`
- LOOP_CNT_WIDTH, 11, width of each loop count
- NUM_LOOPS, 4, number of loop slots (2..8)
- LOOP_IDX_W (localparam), clog2(NUM_LOOPS), slot index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start pulse
- upc_start  in  UINST_ADDR_WIDTH  first microinstruction address
- done  in  1  end-of-program flag from the microinstruction
- stall  in  1  freeze sequencing for this cycle
- loop_count  in  NUM_LOOPS*LOOP_CNT_WIDTH  slot i count at bits [i*LOOP_CNT_WIDTH +: LOOP_CNT_WIDTH]
- st_en / st_idx  in  1 / LOOP_IDX_W  loop-start marker and slot
- up_en / up_idx  in  1 / LOOP_IDX_W  loop-end marker and slot
- jump_en / jump_addr  in  1 / UINST_ADDR_WIDTH  unconditional jump
- upc  out  UINST_ADDR_WIDTH  registered microinstruction address
- busy  out  1  high in RUN
- finish  out  1  one-cycle pulse when a run ends via `done`
- loop_act  out  NUM_LOOPS  bit i high while slot i counter is nonzero

## Operation
- FSM states: IDLE, RUN. IDLE→RUN on `start`. RUN→IDLE on `done` (when `start` is low). `start` in RUN restarts: state stays RUN.
- Next-`upc` priority, evaluated every cycle:
  1. `start` → `upc_start`; all loop addresses and counters cleared.
  2. `done` in RUN → 0.
  3. IDLE or `stall` → hold.
  4. Loop branch-back.
  5. `jump_en` → `jump_addr`.
  6. Otherwise `upc`+1, wrapping modulo 2^UINST_ADDR_WIDTH.
- `done` in IDLE is ignored.
- Loop store (`st_en`, RUN, no stall):
  - slot `st_idx` address ← `upc`+1, so the body starts after the marker;
  - slot `st_idx` counter ← its `loop_count` field;
  - count N gives N body executions; N=0 behaves as N=1.
- Loop update (`up_en`, RUN, no stall), slot k = `up_idx`:
  - if cnt[k] > 1: branch to addr[k], cnt[k] ← cnt[k]-1;
  - else: fall through to rule 5/6, cnt[k] ← 0.
- Simultaneous `st_en` and `up_en`:
  - different slots: both act;
  - same slot: store wins and update is ignored. Single-instruction loops are unsupported.
- `up_en` and `jump_en` together: the branch wins if taken, otherwise the jump is taken.
- `stall` freezes `upc`, loop addresses and counters. `start` and `done` override `stall`.
- Leaving RUN via `done` clears all loop addresses and counters.
- Loops nest by using distinct slots. Reusing an active slot overwrites it.

## Timing
- Reset: `upc`=0, `busy`=0, `finish`=0, `loop_act`=0, state IDLE, all slots 0.
- `upc` is registered. Control inputs are sampled at edge t and decoded from the instruction at `upc`(t). The new `upc` is visible after edge t+1; there are no bubbles.
- `start` at cycle t → `upc`=`upc_start` and `busy`=1 from cycle t+1.
- `done` at cycle t (RUN) → `upc`=0, `busy`=0 and `finish`=1 for exactly cycle t+1.
- `loop_act` is registered from the counters and updates one cycle after the store or update.
- `rst` asserted mid-run forces the reset state immediately, independent of `clk`. The first `start` after release behaves normally.

## Test plan
- Reset/idle: assert `rst` mid-run at `upc`=0x23 → `upc`=0, `busy`=0 immediately. In IDLE, toggling `up_en`/`jump_en` leaves `upc`=0.
- Single loop: `upc_start`=0x10, `st_en` slot 0 at 0x10 with count 3, `up_en` slot 0 at 0x12.
  - `upc` sequence: 10,11,12,11,12,11,12,13.
  - `loop_act[0]` is high from the cycle after 0x10 and low after the last 0x12.
- Nested loops (NUM_LOOPS=4):
  - outer slot 2, count 2, store at 0x20, update at 0x25;
  - inner slot 1, count 3, store at 0x21, update at 0x23;
  - required: 0x22 executes 6 times, 0x24 twice, exit to 0x26.
- Counts 0 and 1: each executes the body once and falls through. A count of all ones (2047) branches back 2046 times.
- Stall/jump priority:
  - `stall` for 3 cycles at `upc`=0x12 → `upc` and counters frozen;
  - `up_en` with an exhausted counter and `jump_en`=1, `jump_addr`=0x40 → `upc`=0x40;
  - with a live counter, the branch is taken instead.
- Done/restart:
  - `done` at `upc`=0x30 → `finish` is a 1-cycle pulse, `upc`=0, `busy`=0;
  - `start` during RUN with `upc_start`=0x50 → `upc`=0x50, all `loop_act` bits cleared, `busy` stays 1;
  - `start` and `done` in the same cycle → restart wins.
